// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Data-memory stage behind the load-store queue. Each issued op (load/store,
//   word/byte) performs one access to a word-organised data memory after a
//   fixed latency and produces exactly one completion pulse for writeback/ROB.
//   Loads whose data was already forwarded by the LSQ skip memory and complete
//   on the next edge. A one-entry pending buffer absorbs an op that arrives
//   while another is in flight; a further arrival is dropped with overrun.
//
//   Handshake: issueValid is a one-cycle pulse with no ready/back-pressure.
//   An op is accepted at the edge where issueValid=1 and pcIn!=0, unless both
//   the in-flight slot and the pending buffer remain occupied after that edge,
//   in which case it is dropped and overrun pulses for one cycle.
//
// Parameters
//   DEPTH        data memory size in 32-bit words (power of 2)
//   MEM_LATENCY  edges from acceptance to wbValid for memory ops (>=1)
//   INIT_FILE    hex image name (not read by this implementation)
//
// Configuration macro
//   MEM_ACCESS_INIT_EN  defined: memory left untouched by rstn.
//                       Undefined: every word is cleared while rstn is low.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   issueValid, pcIn,         issued op: pc, byte address, 0 load / 1 store,
//   addressIn, loadStore,     0 word / 1 byte, store data, LSQ forwarding
//   storeSize, swData,        flags and forwarded load data
//   fromLSQ, complete, lwData
//   busy                      an op is in flight (ACCESS state)
//   wbValid, wbPc, wbData,    one-cycle completion pulse with its pc, load
//   wbIsStore, misaligned     result (0 for stores), store flag, misalign flag
//   overrun                   one-cycle pulse: issued op dropped
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int    DEPTH       = 1024,
   parameter int    MEM_LATENCY = 2,
   parameter string INIT_FILE   = "dmem.hex"
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        issueValid,
   input  logic [31:0] pcIn,
   input  logic [31:0] addressIn,
   input  logic        loadStore,
   input  logic        storeSize,
   input  logic [31:0] swData,
   input  logic        fromLSQ,
   input  logic        complete,
   input  logic [31:0] lwData,
   output logic        busy,
   output logic        wbValid,
   output logic [31:0] wbPc,
   output logic [31:0] wbData,
   output logic        wbIsStore,
   output logic        misaligned,
   output logic        overrun
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic {S_IDLE, S_ACCESS} state_e;

   typedef struct packed {
      logic [31:0]   pc;
      logic [AW+1:0] addr;      // bits above the memory index are dropped (wrap)
      logic          is_store;
      logic          is_byte;
      logic          fwd;       // load completed by LSQ forwarding
      logic [31:0]   data;      // store data for stores, forwarded data for loads
   } op_t;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   op_t           op_q, op_d, pend_q, pend_d, new_op;
   logic          pend_v_q, pend_v_d;
   logic          wb_valid_q, wb_valid_d;
   logic [31:0]   wb_pc_q, wb_pc_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic          wb_is_store_q, wb_is_store_d;
   logic          mis_q, mis_d;
   logic          overrun_q, overrun_d;

   logic [31:0]   mem_q [DEPTH];
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [AW-1:0] widx;
   logic [1:0]    lane;
   logic [31:0]   rd_word;
   logic [7:0]    rd_byte;
   logic [31:0]   rd_result;
   logic          op_mis;
   logic          issue;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^addressIn[31:AW+2];

   // pc==0 marks a bubble from the LSQ and is never accepted.
   assign issue  = issueValid && (pcIn != 32'd0);
   // Only loads can be satisfied by forwarding; stores always reach memory.
   assign new_op = '{pc:       pcIn,
                     addr:     addressIn[AW+1:0],
                     is_store: loadStore,
                     is_byte:  storeSize,
                     fwd:      ~loadStore & fromLSQ & complete,
                     data:     loadStore ? swData : lwData};

   function automatic logic [CW-1:0] start_cnt(input op_t op);
      return op.fwd ? '0 : CW'(MEM_LATENCY - 1);
   endfunction

   // Access datapath for the in-flight op; only used on its completing edge.
   always_comb begin
      widx      = op_q.addr[AW+1:2];
      lane      = op_q.addr[1:0];
      rd_word   = mem_q[widx];
      rd_byte   = rd_word[{lane, 3'b000} +: 8];
      mem_wdata = op_q.data;
      if (op_q.is_byte) begin
         mem_wdata = rd_word;
         mem_wdata[{lane, 3'b000} +: 8] = op_q.data[7:0];
      end
      if (op_q.is_store)      rd_result = 32'd0;
      else if (op_q.fwd)      rd_result = op_q.data;
      else if (op_q.is_byte)  rd_result = {{24{rd_byte[7]}}, rd_byte};
      else                    rd_result = rd_word;
      op_mis = ~op_q.is_byte & ~op_q.fwd & (lane != 2'd0);
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      pend_d        = pend_q;
      pend_v_d      = pend_v_q;
      wb_valid_d    = 1'b0;
      wb_pc_d       = wb_pc_q;
      wb_data_d     = wb_data_q;
      wb_is_store_d = wb_is_store_q;
      mis_d         = 1'b0;
      overrun_d     = 1'b0;
      mem_we        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (issue) begin
               op_d    = new_op;
               cnt_d   = start_cnt(new_op);
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               wb_valid_d    = 1'b1;
               wb_pc_d       = op_q.pc;
               wb_data_d     = rd_result;
               wb_is_store_d = op_q.is_store;
               mis_d         = op_mis;
               mem_we        = op_q.is_store;
               // Successor order: buffered op first, then the op arriving now.
               if (pend_v_q) begin
                  op_d  = pend_q;
                  cnt_d = start_cnt(pend_q);
                  if (issue) pend_d = new_op;
                  else       pend_v_d = 1'b0;
               end else if (issue) begin
                  op_d  = new_op;
                  cnt_d = start_cnt(new_op);
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (issue) begin
                  if (!pend_v_q) begin
                     pend_d   = new_op;
                     pend_v_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         op_q          <= '0;
         pend_q        <= '0;
         pend_v_q      <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_pc_q       <= '0;
         wb_data_q     <= '0;
         wb_is_store_q <= 1'b0;
         mis_q         <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         pend_q        <= pend_d;
         pend_v_q      <= pend_v_d;
         wb_valid_q    <= wb_valid_d;
         wb_pc_q       <= wb_pc_d;
         wb_data_q     <= wb_data_d;
         wb_is_store_q <= wb_is_store_d;
         mis_q         <= mis_d;
         overrun_q     <= overrun_d;
      end
   end

`ifdef MEM_ACCESS_INIT_EN
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[widx] <= mem_wdata;
   end
`else
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[widx] <= mem_wdata;
      end
   end
`endif

   assign busy       = (state_q == S_ACCESS);
   assign wbValid    = wb_valid_q;
   assign wbPc       = wb_pc_q;
   assign wbData     = wb_data_q;
   assign wbIsStore  = wb_is_store_q;
   assign misaligned = mis_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Two instances: dut_a (MEM_LATENCY=2) for the directed scenarios and
//   dut_b (MEM_LATENCY=3) for pending/overrun and randomized traffic. The
//   random test predicts completions from a schedule of accepted ops (each op
//   finishes at max(issue edge, previous op's finish) + latency, at most two
//   outstanding) and a reference memory updated at each completion.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
   localparam int DEPTH = 1024;
   localparam int LAT_B = 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic        a_valid = 0, a_ls = 0, a_sz = 0, a_from = 0, a_cmp = 0;
   logic [31:0] a_pc = 0, a_addr = 0, a_sw = 0, a_lw = 0;
   logic        a_busy, a_wbv, a_wbs, a_mis, a_ovr;
   logic [31:0] a_wbpc, a_wbd;

   logic        b_valid = 0, b_ls = 0, b_sz = 0, b_from = 0, b_cmp = 0;
   logic [31:0] b_pc = 0, b_addr = 0, b_sw = 0, b_lw = 0;
   logic        b_busy, b_wbv, b_wbs, b_mis, b_ovr;
   logic [31:0] b_wbpc, b_wbd;

   mem_access_unit #(.DEPTH(DEPTH), .MEM_LATENCY(2)) dut_a (
      .clk(clk), .rstn(rstn), .issueValid(a_valid), .pcIn(a_pc), .addressIn(a_addr),
      .loadStore(a_ls), .storeSize(a_sz), .swData(a_sw), .fromLSQ(a_from),
      .complete(a_cmp), .lwData(a_lw), .busy(a_busy), .wbValid(a_wbv), .wbPc(a_wbpc),
      .wbData(a_wbd), .wbIsStore(a_wbs), .misaligned(a_mis), .overrun(a_ovr));

   mem_access_unit #(.DEPTH(DEPTH), .MEM_LATENCY(LAT_B)) dut_b (
      .clk(clk), .rstn(rstn), .issueValid(b_valid), .pcIn(b_pc), .addressIn(b_addr),
      .loadStore(b_ls), .storeSize(b_sz), .swData(b_sw), .fromLSQ(b_from),
      .complete(b_cmp), .lwData(b_lw), .busy(b_busy), .wbValid(b_wbv), .wbPc(b_wbpc),
      .wbData(b_wbd), .wbIsStore(b_wbs), .misaligned(b_mis), .overrun(b_ovr));

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic issue_a(input logic [31:0] pc, input logic [31:0] addr, input logic ls,
                          input logic sz, input logic [31:0] data, input logic fwd);
      @(negedge clk);
      a_valid = 1'b1; a_pc = pc; a_addr = addr; a_ls = ls; a_sz = sz;
      a_from = fwd; a_cmp = fwd;
      a_sw = ls ? data : $urandom();
      a_lw = ls ? $urandom() : data;
      @(negedge clk);
      a_valid = 1'b0; a_pc = 32'd0;
   endtask

   // Returns at the negedge where wbValid is seen; k = edges after the issue edge.
   task automatic wait_wb_a(output int k);
      k = 0;
      while (!a_wbv && k < 20) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      n_tests++; if ({a_busy, a_wbv, a_wbs, a_mis, a_ovr} !== 5'b0) begin n_fail++; $display("FAIL reset_a_flags: got %b want 00000", {a_busy, a_wbv, a_wbs, a_mis, a_ovr}); end
      n_tests++; if (a_wbpc !== 32'd0) begin n_fail++; $display("FAIL reset_a_wbpc: got %h want 0", a_wbpc); end
      n_tests++; if (a_wbd !== 32'd0) begin n_fail++; $display("FAIL reset_a_wbdata: got %h want 0", a_wbd); end
      n_tests++; if ({b_busy, b_wbv, b_wbs, b_mis, b_ovr} !== 5'b0) begin n_fail++; $display("FAIL reset_b_flags: got %b want 00000", {b_busy, b_wbv, b_wbs, b_mis, b_ovr}); end
      rstn = 1'b1;
   endtask

   task automatic test_store_load_word();
      int k;
      issue_a(32'h4, 32'h100, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
      n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", a_busy); end
      wait_wb_a(k);
      n_tests++; if (k != 2) begin n_fail++; $display("FAIL t1_store_latency: got %0d want 2", k); end
      n_tests++; if (a_wbpc !== 32'h4) begin n_fail++; $display("FAIL t1_store_pc: got %h want 4", a_wbpc); end
      n_tests++; if ({a_wbs, a_mis} !== 2'b10) begin n_fail++; $display("FAIL t1_store_flags: got %b want 10", {a_wbs, a_mis}); end
      n_tests++; if (a_wbd !== 32'd0) begin n_fail++; $display("FAIL t1_store_data: got %h want 0", a_wbd); end
      @(negedge clk);
      n_tests++; if ({a_wbv, a_busy} !== 2'b00) begin n_fail++; $display("FAIL t1_pulse_end: got %b want 00", {a_wbv, a_busy}); end
      n_tests++; if (a_wbpc !== 32'h4) begin n_fail++; $display("FAIL t1_pc_hold: got %h want 4", a_wbpc); end
      issue_a(32'h8, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
      wait_wb_a(k);
      n_tests++; if (k != 2) begin n_fail++; $display("FAIL t1_load_latency: got %0d want 2", k); end
      n_tests++; if (a_wbd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_load_data: got %h want deadbeef", a_wbd); end
      n_tests++; if ({a_wbs, a_mis} !== 2'b00) begin n_fail++; $display("FAIL t1_load_flags: got %b want 00", {a_wbs, a_mis}); end
      n_tests++; if (a_wbpc !== 32'h8) begin n_fail++; $display("FAIL t1_load_pc: got %h want 8", a_wbpc); end
   endtask

   task automatic test_byte_lanes();
      int k;
      issue_a(32'h10, 32'h100, 1'b1, 1'b0, 32'h11223344, 1'b0); wait_wb_a(k);
      issue_a(32'h14, 32'h101, 1'b1, 1'b1, 32'hAAAAAA7F, 1'b0); wait_wb_a(k);
      n_tests++; if (a_mis !== 1'b0) begin n_fail++; $display("FAIL t2_byte_store_mis: got %b want 0", a_mis); end
      issue_a(32'h18, 32'h101, 1'b0, 1'b1, 32'h0, 1'b0); wait_wb_a(k);
      n_tests++; if (a_wbd !== 32'h0000007F) begin n_fail++; $display("FAIL t2_byte_load_pos: got %h want 0000007f", a_wbd); end
      issue_a(32'h1C, 32'h103, 1'b1, 1'b1, 32'h55555580, 1'b0); wait_wb_a(k);
      issue_a(32'h20, 32'h103, 1'b0, 1'b1, 32'h0, 1'b0); wait_wb_a(k);
      n_tests++; if (a_wbd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL t2_byte_load_neg: got %h want ffffff80", a_wbd); end
      issue_a(32'h24, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0); wait_wb_a(k);
      n_tests++; if (a_wbd !== 32'h80227F44) begin n_fail++; $display("FAIL t2_word_merge: got %h want 80227f44", a_wbd); end
   endtask

   task automatic test_forward();
      int k;
      issue_a(32'hC, 32'h102, 1'b0, 1'b0, 32'h1234, 1'b1); wait_wb_a(k);
      n_tests++; if (k != 1) begin n_fail++; $display("FAIL t3_fwd_latency: got %0d want 1", k); end
      n_tests++; if (a_wbd !== 32'h1234) begin n_fail++; $display("FAIL t3_fwd_data: got %h want 1234", a_wbd); end
      n_tests++; if ({a_wbs, a_mis} !== 2'b00) begin n_fail++; $display("FAIL t3_fwd_flags: got %b want 00", {a_wbs, a_mis}); end
      issue_a(32'h28, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0); wait_wb_a(k);
      n_tests++; if (a_wbd !== 32'h80227F44) begin n_fail++; $display("FAIL t3_mem_untouched: got %h want 80227f44", a_wbd); end
   endtask

   task automatic test_misaligned_wrap();
      int k;
      issue_a(32'h30, 32'h102, 1'b0, 1'b0, 32'h0, 1'b0); wait_wb_a(k);
      n_tests++; if (a_mis !== 1'b1) begin n_fail++; $display("FAIL t5_misaligned: got %b want 1", a_mis); end
      n_tests++; if (a_wbd !== 32'h80227F44) begin n_fail++; $display("FAIL t5_mis_data: got %h want 80227f44", a_wbd); end
      issue_a(32'h34, DEPTH * 4 + 32'h100, 1'b0, 1'b0, 32'h0, 1'b0); wait_wb_a(k);
      n_tests++; if (a_wbd !== 32'h80227F44) begin n_fail++; $display("FAIL t5_wrap_data: got %h want 80227f44", a_wbd); end
      n_tests++; if (a_mis !== 1'b0) begin n_fail++; $display("FAIL t5_wrap_mis: got %b want 0", a_mis); end
   endtask

   task automatic test_pc_zero();
      int seen = 0;
      issue_a(32'h0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
      n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL pc0_busy: got %b want 0", a_busy); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (a_wbv) seen++;
      end
      n_tests++; if (seen != 0) begin n_fail++; $display("FAIL pc0_no_wb: got %0d completions want 0", seen); end
   endtask

   task automatic test_pending_overrun();
      int pcs[$];
      int ks[$];
      @(negedge clk);
      b_valid = 1'b1; b_pc = 32'h10; b_addr = 32'h0; b_ls = 1'b0; b_sz = 1'b0; b_from = 1'b0; b_cmp = 1'b0;
      @(negedge clk);
      n_tests++; if (b_ovr !== 1'b0) begin n_fail++; $display("FAIL t4_ovr_k0: got %b want 0", b_ovr); end
      b_pc = 32'h14;
      @(negedge clk);
      n_tests++; if (b_ovr !== 1'b0) begin n_fail++; $display("FAIL t4_ovr_k1: got %b want 0", b_ovr); end
      b_pc = 32'h18;
      @(negedge clk);
      n_tests++; if (b_ovr !== 1'b1) begin n_fail++; $display("FAIL t4_ovr_k2: got %b want 1", b_ovr); end
      b_valid = 1'b0; b_pc = 32'h0;
      for (int k = 3; k <= 14; k++) begin
         @(negedge clk);
         if (b_wbv) begin pcs.push_back(int'(b_wbpc)); ks.push_back(k); end
         if (k == 3) begin
            n_tests++; if (b_ovr !== 1'b0) begin n_fail++; $display("FAIL t4_ovr_pulse: got %b want 0", b_ovr); end
         end
         if (k == 4) begin
            n_tests++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL t4_busy_b2b: got %b want 1", b_busy); end
         end
      end
      n_tests++;
      if (pcs.size() != 2) begin
         n_fail++; $display("FAIL t4_count: got %0d completions want 2", pcs.size());
      end else if (pcs[0] != 32'h10 || ks[0] != 3 || pcs[1] != 32'h14 || ks[1] != 6) begin
         n_fail++; $display("FAIL t4_order: got pc %h@%0d pc %h@%0d want 10@3 14@6", pcs[0], ks[0], pcs[1], ks[1]);
      end
   endtask

   task automatic test_reset_mid_access();
      int k;
      int seen = 0;
      issue_a(32'h40, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
      rstn = 1'b0;
      #1;
      n_tests++; if ({a_busy, a_wbv} !== 2'b00) begin n_fail++; $display("FAIL t6_reset_busy: got %b want 00", {a_busy, a_wbv}); end
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (a_wbv) seen++;
      end
      n_tests++; if (seen != 0) begin n_fail++; $display("FAIL t6_discarded: got %0d completions want 0", seen); end
      issue_a(32'h44, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0); wait_wb_a(k);
      n_tests++; if (a_wbd !== 32'd0 || k != 2) begin n_fail++; $display("FAIL t6_mem_cleared: got %h lat %0d want 0 lat 2", a_wbd, k); end
   endtask

   typedef struct {
      logic [31:0] pc, addr, sw, lw;
      logic        ls, sz, fwd;
      int          done;
   } mop_t;

   task automatic test_random();
      mop_t        sb[$];
      mop_t        op;
      logic [31:0] ref_mem [DEPTH];
      logic [31:0] exp_pc = 0, exp_d = 0, word, res;
      logic [7:0]  bv;
      logic        exp_v = 0, exp_s = 0, exp_m = 0, exp_ovr = 0, exp_busy = 0, do_issue;
      int          idx, sh, start;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
      pulse_reset();
      for (int cyc = 0; cyc <= 400; cyc++) begin
         @(negedge clk);
         if (cyc > 0) begin
            n_tests++; if (b_wbv !== exp_v) begin n_fail++; $display("FAIL rnd_wbvalid c%0d: got %b want %b", cyc, b_wbv, exp_v); end
            n_tests++; if (b_ovr !== exp_ovr) begin n_fail++; $display("FAIL rnd_overrun c%0d: got %b want %b", cyc, b_ovr, exp_ovr); end
            n_tests++; if (b_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, b_busy, exp_busy); end
            n_tests++; if (b_wbpc !== exp_pc) begin n_fail++; $display("FAIL rnd_wbpc c%0d: got %h want %h", cyc, b_wbpc, exp_pc); end
            n_tests++; if (b_wbd !== exp_d) begin n_fail++; $display("FAIL rnd_wbdata c%0d: got %h want %h", cyc, b_wbd, exp_d); end
            if (exp_v) begin
               n_tests++; if ({b_wbs, b_mis} !== {exp_s, exp_m}) begin n_fail++; $display("FAIL rnd_flags c%0d: got %b want %b", cyc, {b_wbs, b_mis}, {exp_s, exp_m}); end
            end
         end
         if (cyc == 400) break;
         do_issue = (cyc < 380) && ($urandom_range(0, 99) < 55);
         b_valid = do_issue;
         b_pc    = ($urandom_range(0, 15) == 0) ? 32'd0 : (32'($urandom_range(1, 16'hFFFF)) << 2);
         b_addr  = ($urandom_range(0, 1) ? DEPTH * 4 : 0) + 32'($urandom_range(0, 63));
         b_ls    = 1'($urandom_range(0, 1));
         b_sz    = 1'($urandom_range(0, 1));
         b_from  = 1'($urandom_range(0, 1));
         b_cmp   = 1'($urandom_range(0, 1));
         b_sw    = $urandom();
         b_lw    = $urandom();
         // Model for the coming edge (index cyc).
         exp_v = 1'b0; exp_ovr = 1'b0; exp_m = 1'b0;
         if (sb.size() > 0 && sb[0].done == cyc) begin
            op  = sb.pop_front();
            idx = int'((op.addr >> 2) % DEPTH);
            sh  = int'(op.addr % 4) * 8;
            word = ref_mem[idx];
            res  = 32'd0;
            if (op.fwd) begin
               res = op.lw;
            end else if (!op.ls) begin
               if (op.sz) begin bv = 8'(word >> sh); res = {{24{bv[7]}}, bv}; end
               else begin res = word; exp_m = (op.addr % 4) != 0; end
            end else begin
               if (op.sz) ref_mem[idx] = (word & ~(32'hFF << sh)) | ((op.sw & 32'hFF) << sh);
               else begin ref_mem[idx] = op.sw; exp_m = (op.addr % 4) != 0; end
            end
            exp_v = 1'b1; exp_pc = op.pc; exp_d = res; exp_s = op.ls;
         end
         if (do_issue && b_pc != 32'd0) begin
            if (sb.size() >= 2) begin
               exp_ovr = 1'b1;
            end else begin
               op.pc = b_pc; op.addr = b_addr; op.sw = b_sw; op.lw = b_lw;
               op.ls = b_ls; op.sz = b_sz; op.fwd = ~b_ls & b_from & b_cmp;
               start = cyc;
               if (sb.size() > 0 && sb[$].done > start) start = sb[$].done;
               op.done = start + (op.fwd ? 1 : LAT_B);
               sb.push_back(op);
            end
         end
         exp_busy = sb.size() > 0;
      end
      b_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_store_load_word();
      test_byte_lanes();
      test_forward();
      test_misaligned_wrap();
      test_pc_zero();
      test_pending_overrun();
      test_reset_mid_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
